// File: rtl/bram_bist_driver.sv
// bram_bist_driver: BIST requester for a 1-write / 4-read block RAM.
// Fills every address with a deterministic pattern, reads it back four
// addresses per cycle over the four read ports, and reports pass/fail,
// a saturating mismatch count and the first failing address.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// WRITE  | we=1, one address per cycle, 0..DEPTH_MEM-1
// READ   | four consecutive read addresses per cycle
// DRAIN  | last read group's data is being compared
// DONE   | results held, done=1, waiting for the next start
module bram_bist_driver #(
  parameter int unsigned         WID_MEM   = 1,
  parameter int unsigned         DEPTH_MEM = 128,
  parameter int unsigned         ADDR_W    = 7,
  parameter logic [WID_MEM-1:0]  SEED      = '0,
  parameter int unsigned         ERR_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pat_inv,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_err_valid,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [WID_MEM-1:0] din,
  output logic [ADDR_W-1:0]  raddr1,
  output logic [ADDR_W-1:0]  raddr2,
  output logic [ADDR_W-1:0]  raddr3,
  output logic [ADDR_W-1:0]  raddr4,
  input  logic [WID_MEM-1:0] dout1,
  input  logic [WID_MEM-1:0] dout2,
  input  logic [WID_MEM-1:0] dout3,
  input  logic [WID_MEM-1:0] dout4
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(DEPTH_MEM - 4);

  // Address zero-extended or truncated to the data width, then seeded/inverted.
  function automatic logic [WID_MEM-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    logic [WID_MEM+ADDR_W-1:0] ext;
    ext = {{WID_MEM{1'b0}}, a};
    return ext[WID_MEM-1:0] ^ SEED ^ {WID_MEM{inv}};
  endfunction

  logic [2:0]        state_q, state_d;
  logic              inv_q, inv_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic              check_q, check_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [ADDR_W-1:0] fea_q, fea_d;

  logic [ADDR_W-1:0] lane_addr [4];
  logic [3:0]        miss;
  logic [2:0]        miss_cnt;
  logic [ADDR_W-1:0] first_lane_addr;
  logic [ERR_W:0]    err_sum;

  // Per-lane compare of the registered read data against the expected pattern.
  always_comb begin
    lane_addr[0] = base_q;
    lane_addr[1] = base_q + ADDR_W'(1);
    lane_addr[2] = base_q + ADDR_W'(2);
    lane_addr[3] = base_q + ADDR_W'(3);
    miss[0] = check_q && (dout1 != pat(lane_addr[0], inv_q));
    miss[1] = check_q && (dout2 != pat(lane_addr[1], inv_q));
    miss[2] = check_q && (dout3 != pat(lane_addr[2], inv_q));
    miss[3] = check_q && (dout4 != pat(lane_addr[3], inv_q));
    miss_cnt = {2'b00, miss[0]} + {2'b00, miss[1]} + {2'b00, miss[2]} + {2'b00, miss[3]};
    if (miss[0])      first_lane_addr = lane_addr[0];
    else if (miss[1]) first_lane_addr = lane_addr[1];
    else if (miss[2]) first_lane_addr = lane_addr[2];
    else              first_lane_addr = lane_addr[3];
    err_sum = {1'b0, err_q} + (ERR_W+1)'(miss_cnt);
  end

  // Next-state: sequencing, address counters and result accumulation.
  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    waddr_d = waddr_q;
    rbase_d = rbase_q;
    check_d = 1'b0;
    base_d  = base_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;

    if (check_q) begin
      err_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
      if ((|miss) && !fev_q) begin
        fev_d = 1'b1;
        fea_d = first_lane_addr;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          inv_d   = pat_inv;
          waddr_d = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
        end
      end
      S_WRITE: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = S_READ;
          rbase_d = '0;
        end else begin
          waddr_d = waddr_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        check_d = 1'b1;
        base_d  = rbase_q;
        if (rbase_q == LAST_BASE) state_d = S_DRAIN;
        else                      rbase_d = rbase_q + ADDR_W'(4);
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      inv_q   <= 1'b0;
      waddr_q <= '0;
      rbase_q <= '0;
      check_q <= 1'b0;
      base_q  <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      waddr_q <= waddr_d;
      rbase_q <= rbase_d;
      check_q <= check_d;
      base_q  <= base_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
    end
  end

  // Outputs; the write pair is held after WRITE so an always-enabled port stays harmless.
  always_comb begin
    busy            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    done            = (state_q == S_DONE);
    pass            = done && (err_q == '0);
    err_count       = err_q;
    first_err_valid = fev_q;
    first_err_addr  = fea_q;
    we              = (state_q == S_WRITE);
    waddr           = waddr_q;
    din             = pat(waddr_q, inv_q);
    if (state_q == S_READ) begin
      raddr1 = rbase_q;
      raddr2 = rbase_q + ADDR_W'(1);
      raddr3 = rbase_q + ADDR_W'(2);
      raddr4 = rbase_q + ADDR_W'(3);
    end else begin
      raddr1 = '0;
      raddr2 = '0;
      raddr3 = '0;
      raddr4 = '0;
    end
  end

endmodule
